serial_adder: RTL and testbench

- Bit-serial N-bit adder built around a single full-adder bit slice (sum = a^b^c, carry = ab | (a^b)c) and a registered carry.
- Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Adds them LSB-first, one bit per clock, and presents the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits directly upstream of result consumers and is the sequential counterpart of the combinational full-adder slice.

---
 rtl/serial_adder.sv | 95 +++++++++
 tb/tb_serial_adder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built on one full-adder slice.
// Operands are loaded on an input handshake. They are added LSB-first, one
// bit per clock, through a registered carry. The WIDTH-bit sum and the
// carry-out are then held until the output handshake completes.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             bit_s;
  logic             bit_c;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | ((a ^ b) & c);
  endfunction

  assign bit_s = fa_sum(a_sh[0], b_sh[0], carry);
  assign bit_c = fa_carry(a_sh[0], b_sh[0], carry);

  // Reset gates in_ready directly, so no operand is accepted while rst is high.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign sum_out   = sum_sh;
  assign carry_out = carry;

  // Sequence the operation: load operands, shift one bit per cycle, then hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= carry_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          // Each new sum bit enters at the MSB. After WIDTH shifts, the first bit has reached bit 0.
          sum_sh <= {bit_s, sum_sh[WIDTH-1:1]};
          carry  <= bit_c;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder at WIDTH=2, 8 and 32.
module tb_serial_adder;

  logic clk;
  logic rst;

  // Shared drive signals. Only the instance selected by sel sees in_valid.
  int          sel;
  logic        in_valid_g;
  logic [31:0] a_g;
  logic [31:0] b_g;
  logic        cin_g;
  logic        out_ready_g;

  logic        in_ready2, out_valid2, cout2;
  logic [1:0]  sum2;
  logic        in_ready8, out_valid8, cout8;
  logic [7:0]  sum8;
  logic        in_ready32, out_valid32, cout32;
  logic [31:0] sum32;

  logic        rdy_g, vld_g, cout_g;
  logic [31:0] sum_g;

  int checks;
  int failures;

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_g && (sel == 2)), .in_ready(in_ready2),
    .a_in(a_g[1:0]), .b_in(b_g[1:0]), .carry_in(cin_g),
    .out_valid(out_valid2), .out_ready(out_ready_g),
    .sum_out(sum2), .carry_out(cout2)
  );

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_g && (sel == 8)), .in_ready(in_ready8),
    .a_in(a_g[7:0]), .b_in(b_g[7:0]), .carry_in(cin_g),
    .out_valid(out_valid8), .out_ready(out_ready_g),
    .sum_out(sum8), .carry_out(cout8)
  );

  serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_g && (sel == 32)), .in_ready(in_ready32),
    .a_in(a_g), .b_in(b_g), .carry_in(cin_g),
    .out_valid(out_valid32), .out_ready(out_ready_g),
    .sum_out(sum32), .carry_out(cout32)
  );

  always_comb begin
    rdy_g  = 1'b0;
    vld_g  = 1'b0;
    cout_g = 1'b0;
    sum_g  = '0;
    case (sel)
      2:  begin rdy_g = in_ready2;  vld_g = out_valid2;  cout_g = cout2;  sum_g = {30'b0, sum2}; end
      8:  begin rdy_g = in_ready8;  vld_g = out_valid8;  cout_g = cout8;  sum_g = {24'b0, sum8}; end
      32: begin rdy_g = in_ready32; vld_g = out_valid32; cout_g = cout32; sum_g = sum32;         end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation and waits for the result. lat is the number of
  // edges after the accept edge (-1 if the operation was never accepted).
  // The DUT is left in DONE with out_ready low.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        output logic [31:0] s, output logic c, output int lat);
    int guard;
    out_ready_g = 1'b0;
    a_g = a; b_g = b; cin_g = cin;
    in_valid_g = 1'b1;
    guard = 0;
    while (!rdy_g && guard < 50) begin
      step();
      guard++;
    end
    lat = -1;
    if (rdy_g) begin
      step();
      in_valid_g = 1'b0;
      lat = 0;
      while (!vld_g && lat < 80) begin
        step();
        lat++;
      end
    end
    in_valid_g = 1'b0;
    s = sum_g;
    c = cout_g;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (rdy_g !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", rdy_g); end
    checks++;
    if (vld_g !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", vld_g); end
    checks++;
    if (sum_g !== 32'h0 || cout_g !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got sum=%h c=%b want sum=0 c=0", sum_g, cout_g);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy_g !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b want=1", rdy_g); end
  endtask

  task automatic test_basic();
    int k;
    out_ready_g = 1'b0;
    a_g = 32'h5A; b_g = 32'h3C; cin_g = 1'b0;
    in_valid_g = 1'b1;
    step();
    in_valid_g = 1'b0;
    a_g = 32'h0; b_g = 32'h0;
    checks++;
    if (rdy_g !== 1'b0 || vld_g !== 1'b0) begin
      failures++; $display("FAIL basic_run_flags got rdy=%b vld=%b want 0 0", rdy_g, vld_g);
    end
    k = 1;
    while (k < 8) begin
      step();
      checks++;
      if (vld_g !== 1'b0) begin failures++; $display("FAIL basic_early_valid edge=%0d got=%b want=0", k, vld_g); end
      k++;
    end
    step();
    checks++;
    if (vld_g !== 1'b1) begin failures++; $display("FAIL basic_latency got vld=%b want=1", vld_g); end
    checks++;
    if (sum_g !== 32'h96 || cout_g !== 1'b0) begin
      failures++; $display("FAIL basic_sum got sum=%h c=%b want sum=96 c=0", sum_g, cout_g);
    end
    out_ready_g = 1'b1;
    step();
    out_ready_g = 1'b0;
    checks++;
    if (vld_g !== 1'b0 || rdy_g !== 1'b1) begin
      failures++; $display("FAIL basic_release got vld=%b rdy=%b want 0 1", vld_g, rdy_g);
    end
  endtask

  task automatic test_carry();
    logic [31:0] s;
    logic c;
    int lat;
    run_op(32'hFF, 32'h01, 1'b0, s, c, lat);
    checks++;
    if (lat !== 8 || s !== 32'h00 || c !== 1'b1) begin
      failures++; $display("FAIL carry_overflow got lat=%0d sum=%h c=%b want lat=8 sum=00 c=1", lat, s, c);
    end
    out_ready_g = 1'b1; step(); out_ready_g = 1'b0;
    run_op(32'hFF, 32'hFF, 1'b1, s, c, lat);
    checks++;
    if (lat !== 8 || s !== 32'hFF || c !== 1'b1) begin
      failures++; $display("FAIL carry_fresh got lat=%0d sum=%h c=%b want lat=8 sum=ff c=1", lat, s, c);
    end
    out_ready_g = 1'b1; step(); out_ready_g = 1'b0;
    run_op(32'h01, 32'h01, 1'b0, s, c, lat);
    checks++;
    if (s !== 32'h02 || c !== 1'b0) begin
      failures++; $display("FAIL carry_no_leak got sum=%h c=%b want sum=02 c=0", s, c);
    end
    out_ready_g = 1'b1; step(); out_ready_g = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] s;
    logic c;
    int lat;
    run_op(32'h12, 32'h34, 1'b0, s, c, lat);
    checks++;
    if (lat !== 8 || s !== 32'h46 || c !== 1'b0) begin
      failures++; $display("FAIL bp_result got lat=%0d sum=%h c=%b want lat=8 sum=46 c=0", lat, s, c);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid_g = 1'b1;
      a_g = 32'hA0 + 32'(i); b_g = 32'h5F; cin_g = 1'b1;
      step();
      checks++;
      if (vld_g !== 1'b1 || rdy_g !== 1'b0 || sum_g !== 32'h46 || cout_g !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b sum=%h c=%b want 1 0 46 0", i, vld_g, rdy_g, sum_g, cout_g);
      end
    end
    in_valid_g = 1'b0;
    out_ready_g = 1'b1;
    step();
    out_ready_g = 1'b0;
    checks++;
    if (vld_g !== 1'b0 || rdy_g !== 1'b1) begin
      failures++; $display("FAIL bp_release got vld=%b rdy=%b want 0 1", vld_g, rdy_g);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] s;
    logic c;
    int lat;
    out_ready_g = 1'b0;
    a_g = 32'h80; b_g = 32'h80; cin_g = 1'b0;
    in_valid_g = 1'b1;
    step();
    in_valid_g = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    checks++;
    if (vld_g !== 1'b0 || rdy_g !== 1'b0) begin
      failures++; $display("FAIL midrst_flags got vld=%b rdy=%b want 0 0", vld_g, rdy_g);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy_g !== 1'b1 || sum_g !== 32'h0 || cout_g !== 1'b0) begin
      failures++; $display("FAIL midrst_cleared got rdy=%b sum=%h c=%b want 1 0 0", rdy_g, sum_g, cout_g);
    end
    run_op(32'h01, 32'h02, 1'b0, s, c, lat);
    checks++;
    if (lat !== 8 || s !== 32'h03 || c !== 1'b0) begin
      failures++; $display("FAIL midrst_next got lat=%0d sum=%h c=%b want lat=8 sum=03 c=0", lat, s, c);
    end
    out_ready_g = 1'b1; step(); out_ready_g = 1'b0;
  endtask

  // Streams n random operations with in_valid and out_ready held high, checking
  // the accept spacing and every result against a+b+cin.
  task automatic test_back_to_back(input int w, input int n);
    logic [32:0] exp_q[$];
    logic [63:0] full;
    logic [63:0] mask;
    logic [32:0] exp_v;
    logic        acc;
    int          n_acc, n_done, cyc, last_acc, limit;
    sel = w;
    mask = (64'd1 << w) - 64'd1;
    n_acc = 0; n_done = 0; cyc = 0; last_acc = -1;
    limit = n * (w + 2) + 60;
    out_ready_g = 1'b1;
    a_g = $urandom() & mask[31:0];
    b_g = $urandom() & mask[31:0];
    cin_g = 1'($urandom_range(0, 1));
    in_valid_g = 1'b1;
    #1;
    while (n_done < n && cyc < limit) begin
      acc = rdy_g && in_valid_g;
      step();
      cyc++;
      if (acc) begin
        full = 64'(a_g) + 64'(b_g) + 64'(cin_g);
        exp_v = {full[w], full[31:0] & mask[31:0]};
        exp_q.push_back(exp_v);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== w + 2) begin
            failures++; $display("FAIL b2b_spacing w=%0d got=%0d want=%0d", w, cyc - last_acc, w + 2);
          end
        end
        last_acc = cyc;
        n_acc++;
        if (n_acc < n) begin
          a_g = $urandom() & mask[31:0];
          b_g = $urandom() & mask[31:0];
          cin_g = 1'($urandom_range(0, 1));
        end else begin
          in_valid_g = 1'b0;
        end
      end
      if (vld_g) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_unexpected w=%0d got sum=%h c=%b want no result", w, sum_g, cout_g);
        end else begin
          exp_v = exp_q.pop_front();
          if ({cout_g, sum_g} !== exp_v) begin
            failures++;
            $display("FAIL b2b_result w=%0d op=%0d got c=%b sum=%h want c=%b sum=%h",
                     w, n_done, cout_g, sum_g, exp_v[32], exp_v[31:0]);
          end
        end
        n_done++;
      end
    end
    checks++;
    if (n_done !== n) begin
      failures++; $display("FAIL b2b_timeout w=%0d got done=%0d want=%0d", w, n_done, n);
    end
    in_valid_g = 1'b0;
    out_ready_g = 1'b0;
    step();
    step();
    sel = 8;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    sel = 8;
    rst = 1'b1;
    in_valid_g = 1'b0;
    a_g = '0;
    b_g = '0;
    cin_g = 1'b0;
    out_ready_g = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back(8, 1000);
    test_back_to_back(2, 1000);
    test_back_to_back(32, 1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
